hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard/flow controller for the 5-stage MIPS pipeline.
- Watches the ID stage and the EX-stage control outputs of the ID/EX control register (memread, jump, branch result, destination register).
- Drives the stall and flush controls into PC, IF/ID and ID/EX; idex_flush is the clear input of the ID/EX control register.
- Sequences multi-cycle load-use bubbles and taken-branch/jump squash penalties with a small FSM.

Parameters:
LU_BUBBLES, 1, bubble cycles inserted per load-use hazard (1..7)
BR_PENALTY, 1, cycles IF/ID and ID/EX are flushed after taken branch/jump (1..7)
CNT_W, 32, perf counter width (used only with the optional feature)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
id_rs  in  5  rs field of the instruction in ID
id_rt  in  5  rt field of the instruction in ID
id_uses_rs  in  1  ID instruction reads rs
id_uses_rt  in  1  ID instruction reads rt
ex_memread  in  1  instruction in EX is a load
ex_wreg  in  5  destination register of the instruction in EX
ex_branch_taken  in  1  EX resolved beq/bne as taken this cycle
ex_jump  in  1  EX holds a jump this cycle
mem_busy  in  1  data memory not ready; freeze the whole pipeline
pc_stall  out  1  hold PC
ifid_stall  out  1  hold IF/ID
ifid_flush  out  1  clear IF/ID to nop
idex_flush  out  1  clear ID/EX (bubble)
pipe_freeze  out  1  hold EX/MEM and MEM/WB
perf_stall_cnt  out  CNT_W  stall cycles (optional feature)
perf_flush_cnt  out  CNT_W  squash events (optional feature)

Behaviour:
- While rst is low: all state cleared, FSM in RUN, all outputs 0. Reset mid-sequence abandons any bubbles or penalty.
- Outputs are combinational from FSM state plus current inputs. They take effect at the next rising edge, so hazard detection in cycle T inserts the bubble at the end of cycle T.
- Hazard: lu_hit = ex_memread & ex_wreg!=0 & ((id_uses_rs & id_rs==ex_wreg) | (id_uses_rt & id_rt==ex_wreg)).
- Redirect: redir = ex_branch_taken | ex_jump.
- Priority: mem_busy > redir > lu_hit.
- FSM states: RUN, LU_WAIT, BR_FLUSH; 3-bit down-counter cnt.
- RUN:
  - mem_busy: pc_stall, ifid_stall, pipe_freeze = 1, idex_flush = 0; state and cnt unchanged.
  - redir: ifid_flush = idex_flush = 1. If BR_PENALTY>1, go to BR_FLUSH with cnt = BR_PENALTY-1.
  - lu_hit: pc_stall = ifid_stall = idex_flush = 1. If LU_BUBBLES>1, go to LU_WAIT with cnt = LU_BUBBLES-1.
- LU_WAIT:
  - Drives pc_stall = ifid_stall = idex_flush = 1 and decrements cnt; returns to RUN when cnt reaches 1 and is decremented.
  - redir arriving in LU_WAIT preempts: behaves as redir in RUN, remaining bubbles discarded.
- BR_FLUSH: drives ifid_flush = idex_flush = 1, decrements cnt, returns to RUN at cnt==1. lu_hit ignored (squashed instruction).
- mem_busy in any state: freeze outputs only. cnt and state hold, flush outputs forced 0.
- ifid_stall and ifid_flush are never both 1.
- Register $0 never causes a hazard.

Optional Feature:
HAZARD_PERF_CNT_EN
- Defined: perf_stall_cnt increments on every cycle with pc_stall=1. perf_flush_cnt increments on every redir accepted, i.e. entry into a flush and not frozen. Both counters saturate at all-ones and are cleared by rst.
- Undefined: both ports tied to 0 and no counter flops are synthesised.

Decomposition:
- Shared package holds:
  - FSM state encoding: RUN=2'd0, LU_WAIT=2'd1, BR_FLUSH=2'd2.
  - Register-zero constant REG_ZERO=5'd0.
  - Shared localparams for the 3-bit counter width.
- Natural sub-module: hazard_perf_cnt, a saturating counter with enable, instantiated twice under the macro.

Test Plan:
- lw $t0 in EX (ex_memread=1, ex_wreg=8), ID add using rs=8, LU_BUBBLES=1 -> one cycle pc_stall=ifid_stall=idex_flush=1, then all 0.
- Same hazard with ex_wreg=0, or id_uses_rs=0 -> no stall.
- ex_branch_taken=1 with BR_PENALTY=2 -> ifid_flush=idex_flush=1 for exactly 2 cycles. A lu_hit during the second cycle is ignored.
- lu_hit and ex_jump in the same cycle -> flush asserted, pc_stall=0.
- LU_BUBBLES=3, mem_busy pulsed for 2 cycles during the 2nd bubble -> freeze for 2 cycles, total stall 5 cycles, then RUN.
- rst pulsed low while in BR_FLUSH -> outputs 0 immediately (asynchronous), FSM in RUN after release. With HAZARD_PERF_CNT_EN, counters read 0 after release.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// FSM encoding, register-zero constant and the bubble/penalty counter width.
package hazard_ctrl_pkg;

  localparam int unsigned CNT_BITS = 3;
  localparam logic [4:0]  REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StLuWait  = 2'd1,
    StBrFlush = 2'd2
  } state_e;

  // A source operand conflicts with a destination unless it is unused or $0.
  function automatic logic reg_hit(input logic uses, input logic [4:0] src,
                                   input logic [4:0] dst);
    return uses && (src == dst) && (dst != REG_ZERO);
  endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// Saturating event counter with enable, cleared by the asynchronous active-low reset.
module hazard_perf_cnt #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else if (en && (count_q != '1)) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use bubble and branch/jump squash sequencer for the 5-stage MIPS pipeline.
// Optional perf counters are built only when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned LU_BUBBLES = 1,
  parameter int unsigned BR_PENALTY = 1,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             ex_memread,
  input  logic [4:0]       ex_wreg,
  input  logic             ex_branch_taken,
  input  logic             ex_jump,
  input  logic             mem_busy,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             pipe_freeze,
  output logic [CNT_W-1:0] perf_stall_cnt,
  output logic [CNT_W-1:0] perf_flush_cnt
);

  localparam logic [CNT_BITS-1:0] LuCntInit = CNT_BITS'(LU_BUBBLES - 1);
  localparam logic [CNT_BITS-1:0] BrCntInit = CNT_BITS'(BR_PENALTY - 1);
  localparam logic [CNT_BITS-1:0] CntOne    = CNT_BITS'(1);

  state_e              state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;

  logic lu_hit, redir, redir_accept;
  logic pc_stall_c, ifid_stall_c, ifid_flush_c, idex_flush_c, pipe_freeze_c;

  assign lu_hit = ex_memread &&
                  (reg_hit(id_uses_rs, id_rs, ex_wreg) || reg_hit(id_uses_rt, id_rt, ex_wreg));
  assign redir  = ex_branch_taken || ex_jump;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StRun;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    redir_accept  = 1'b0;
    pc_stall_c    = 1'b0;
    ifid_stall_c  = 1'b0;
    ifid_flush_c  = 1'b0;
    idex_flush_c  = 1'b0;
    pipe_freeze_c = 1'b0;

    if (mem_busy) begin
      // Whole pipeline holds; sequencing resumes where it left off.
      pc_stall_c    = 1'b1;
      ifid_stall_c  = 1'b1;
      pipe_freeze_c = 1'b1;
    end else begin
      unique case (state_q)
        StRun, StLuWait: begin
          if (redir) begin
            // A redirect also discards any remaining load-use bubbles.
            redir_accept = 1'b1;
            ifid_flush_c = 1'b1;
            idex_flush_c = 1'b1;
            if (BR_PENALTY > 1) begin
              state_d = StBrFlush;
              cnt_d   = BrCntInit;
            end else begin
              state_d = StRun;
              cnt_d   = '0;
            end
          end else if (state_q == StLuWait) begin
            pc_stall_c   = 1'b1;
            ifid_stall_c = 1'b1;
            idex_flush_c = 1'b1;
            cnt_d        = cnt_q - CntOne;
            if (cnt_q == CntOne) begin
              state_d = StRun;
            end
          end else if (lu_hit) begin
            pc_stall_c   = 1'b1;
            ifid_stall_c = 1'b1;
            idex_flush_c = 1'b1;
            if (LU_BUBBLES > 1) begin
              state_d = StLuWait;
              cnt_d   = LuCntInit;
            end
          end
        end
        StBrFlush: begin
          // The ID instruction is on the wrong path, so lu_hit is ignored.
          ifid_flush_c = 1'b1;
          idex_flush_c = 1'b1;
          cnt_d        = cnt_q - CntOne;
          if (cnt_q == CntOne) begin
            state_d = StRun;
          end
        end
        default: begin
          state_d = StRun;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are combinational, so they must be masked while reset is held.
  assign pc_stall    = rst && pc_stall_c;
  assign ifid_stall  = rst && ifid_stall_c;
  assign ifid_flush  = rst && ifid_flush_c;
  assign idex_flush  = rst && idex_flush_c;
  assign pipe_freeze = rst && pipe_freeze_c;

`ifdef HAZARD_PERF_CNT_EN
  hazard_perf_cnt #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .en   (pc_stall),
    .count(perf_stall_cnt)
  );

  hazard_perf_cnt #(
    .CNT_W(CNT_W)
  ) u_flush_cnt (
    .clk  (clk),
    .rst  (rst),
    .en   (redir_accept),
    .count(perf_flush_cnt)
  );
`else
  logic unused_redir_accept;
  assign unused_redir_accept = redir_accept;
  assign perf_stall_cnt      = '0;
  assign perf_flush_cnt      = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: two parameterisations driven in lockstep,
// expected responses from a remaining-cycles reference model.
module tb_hazard_ctrl;

  localparam int unsigned LuA  = 3;
  localparam int unsigned BrA  = 2;
  localparam int unsigned LuB  = 1;
  localparam int unsigned BrB  = 1;
  localparam int unsigned CntW = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, ex_wreg = '0;
  logic       id_uses_rs = 1'b0, id_uses_rt = 1'b0, ex_memread = 1'b0;
  logic       ex_branch_taken = 1'b0, ex_jump = 1'b0, mem_busy = 1'b0;

  logic            pc_stall_a, ifid_stall_a, ifid_flush_a, idex_flush_a, pipe_freeze_a;
  logic            pc_stall_b, ifid_stall_b, ifid_flush_b, idex_flush_b, pipe_freeze_b;
  logic [CntW-1:0] ps_cnt_a, pf_cnt_a, ps_cnt_b, pf_cnt_b;

  always #5 clk = ~clk;

  hazard_ctrl #(.LU_BUBBLES(LuA), .BR_PENALTY(BrA), .CNT_W(CntW)) dut_a (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
    .id_uses_rt(id_uses_rt), .ex_memread(ex_memread), .ex_wreg(ex_wreg),
    .ex_branch_taken(ex_branch_taken), .ex_jump(ex_jump), .mem_busy(mem_busy),
    .pc_stall(pc_stall_a), .ifid_stall(ifid_stall_a), .ifid_flush(ifid_flush_a),
    .idex_flush(idex_flush_a), .pipe_freeze(pipe_freeze_a),
    .perf_stall_cnt(ps_cnt_a), .perf_flush_cnt(pf_cnt_a)
  );

  hazard_ctrl #(.LU_BUBBLES(LuB), .BR_PENALTY(BrB), .CNT_W(CntW)) dut_b (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
    .id_uses_rt(id_uses_rt), .ex_memread(ex_memread), .ex_wreg(ex_wreg),
    .ex_branch_taken(ex_branch_taken), .ex_jump(ex_jump), .mem_busy(mem_busy),
    .pc_stall(pc_stall_b), .ifid_stall(ifid_stall_b), .ifid_flush(ifid_flush_b),
    .idex_flush(idex_flush_b), .pipe_freeze(pipe_freeze_b),
    .perf_stall_cnt(ps_cnt_b), .perf_flush_cnt(pf_cnt_b)
  );

  // {pc_stall, ifid_stall, ifid_flush, idex_flush, pipe_freeze}
  typedef struct {
    logic [4:0] oa;
    logic [4:0] ob;
    longint     ps_a, pf_a, ps_b, pf_b;
    string      tag;
  } exp_t;

  exp_t   sb_q[$];
  int     checks = 0;
  int     errors = 0;
  bit     stim_done = 1'b0;

  int     rem_stall_a = 0, rem_flush_a = 0, rem_stall_b = 0, rem_flush_b = 0;
  longint m_ps_a = 0, m_pf_a = 0, m_ps_b = 0, m_pf_b = 0;

  task automatic model_step(input int lub, input int brp, input logic busy, input logic redir,
                            input logic lu, inout int rem_stall, inout int rem_flush,
                            output logic [4:0] o, output logic acc);
    o   = 5'b00000;
    acc = 1'b0;
    if (busy) begin
      o = 5'b11001;
    end else if (redir && rem_flush == 0) begin
      o         = 5'b00110;
      acc       = 1'b1;
      rem_flush = brp - 1;
      rem_stall = 0;
    end else if (rem_flush > 0) begin
      o         = 5'b00110;
      rem_flush = rem_flush - 1;
    end else if (rem_stall > 0) begin
      o         = 5'b11010;
      rem_stall = rem_stall - 1;
    end else if (lu) begin
      o         = 5'b11010;
      rem_stall = lub - 1;
    end
  endtask

  task automatic drive(input logic r, input logic busy, input logic br, input logic jmp,
                       input logic memrd, input logic [4:0] wreg, input logic [4:0] rs_f,
                       input logic [4:0] rt_f, input logic urs, input logic urt,
                       input string tag);
    exp_t e;
    logic lu, acc;
    @(negedge clk);
    rst = r; mem_busy = busy; ex_branch_taken = br; ex_jump = jmp; ex_memread = memrd;
    ex_wreg = wreg; id_rs = rs_f; id_rt = rt_f; id_uses_rs = urs; id_uses_rt = urt;
    lu = memrd && (wreg != 5'd0) && ((urs && rs_f == wreg) || (urt && rt_f == wreg));
    e.tag = tag;
    if (!r) begin
      rem_stall_a = 0; rem_flush_a = 0; rem_stall_b = 0; rem_flush_b = 0;
      m_ps_a = 0; m_pf_a = 0; m_ps_b = 0; m_pf_b = 0;
      e.oa = '0; e.ob = '0;
      e.ps_a = 0; e.pf_a = 0; e.ps_b = 0; e.pf_b = 0;
    end else begin
      // Counters visible this cycle reflect events from earlier cycles only.
      e.ps_a = m_ps_a; e.pf_a = m_pf_a; e.ps_b = m_ps_b; e.pf_b = m_pf_b;
      model_step(LuA, BrA, busy, br || jmp, lu, rem_stall_a, rem_flush_a, e.oa, acc);
      m_ps_a += longint'(e.oa[4]); m_pf_a += longint'(acc);
      model_step(LuB, BrB, busy, br || jmp, lu, rem_stall_b, rem_flush_b, e.ob, acc);
      m_ps_b += longint'(e.ob[4]); m_pf_b += longint'(acc);
    end
    sb_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, "idle");
  endtask

  task automatic check(input string name, input string tag, input longint act,
                       input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s [%s] @%0t: got 0x%0h, expected 0x%0h", name, tag, $time, act, exp);
    end
  endtask

  // Monitor: samples one time unit before each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("outs_a", e.tag, longint'({pc_stall_a, ifid_stall_a, ifid_flush_a,
                                         idex_flush_a, pipe_freeze_a}), longint'(e.oa));
        check("outs_b", e.tag, longint'({pc_stall_b, ifid_stall_b, ifid_flush_b,
                                         idex_flush_b, pipe_freeze_b}), longint'(e.ob));
        check("stall_flush_excl_a", e.tag, longint'(ifid_stall_a & ifid_flush_a), 0);
        check("stall_flush_excl_b", e.tag, longint'(ifid_stall_b & ifid_flush_b), 0);
`ifdef HAZARD_PERF_CNT_EN
        check("perf_stall_a", e.tag, longint'(ps_cnt_a), e.ps_a);
        check("perf_flush_a", e.tag, longint'(pf_cnt_a), e.pf_a);
        check("perf_stall_b", e.tag, longint'(ps_cnt_b), e.ps_b);
        check("perf_flush_b", e.tag, longint'(pf_cnt_b), e.pf_b);
`else
        check("perf_stall_a", e.tag, longint'(ps_cnt_a), 0);
        check("perf_flush_a", e.tag, longint'(pf_cnt_a), 0);
        check("perf_stall_b", e.tag, longint'(ps_cnt_b), 0);
        check("perf_flush_b", e.tag, longint'(pf_cnt_b), 0);
`endif
      end
    end
  end

  // Stimulus
  initial begin
    drive(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, "reset");
    drive(0, 0, 1, 0, 1, 5'd8, 5'd8, 5'd0, 1, 0, "reset_inputs_active");
    idle(2);
    drive(1, 0, 0, 0, 1, 5'd8, 5'd8, 5'd9, 1, 1, "lw_use_rs");
    idle(4);
    drive(1, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1, 1, "lw_reg0");
    drive(1, 0, 0, 0, 1, 5'd8, 5'd8, 5'd3, 0, 1, "lw_rs_unused");
    drive(1, 0, 0, 0, 1, 5'd9, 5'd4, 5'd9, 0, 1, "lw_use_rt");
    idle(3);
    drive(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, "branch_taken");
    drive(1, 0, 0, 0, 1, 5'd8, 5'd8, 5'd0, 1, 0, "lu_in_flush");
    idle(3);
    drive(1, 0, 0, 1, 1, 5'd8, 5'd8, 5'd0, 1, 0, "lu_and_jump");
    idle(3);
    drive(1, 0, 0, 0, 1, 5'd8, 5'd8, 5'd0, 1, 0, "lu3_start");
    drive(1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, "lu3_busy1");
    drive(1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, "lu3_busy2");
    idle(4);
    drive(1, 0, 0, 0, 1, 5'd8, 5'd8, 5'd0, 1, 0, "lu_then_redir");
    drive(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, "redir_preempt");
    idle(3);
    drive(1, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, "jump_pre_reset");
    drive(0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, "reset_in_flush");
    idle(2);
    for (int i = 0; i < 600; i++) begin
      drive(logic'($urandom_range(0, 63) != 0), logic'($urandom_range(0, 7) == 0),
            logic'($urandom_range(0, 9) == 0), logic'($urandom_range(0, 15) == 0),
            logic'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)), "random");
    end
    idle(2);
    stim_done = 1'b1;
  end

  initial begin
    int budget;
    budget = 0;
    while (!(stim_done && sb_q.size() == 0) && budget < 5000) begin
      @(posedge clk);
      budget++;
    end
    if (budget >= 5000) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
